sblk_psum_acc: RTL and testbench

// Parametrised partial-sum accumulation buffer that terminates a superblock stile cascade.

---
 rtl/sblk_psum_acc.sv | 252 +++++++++++++++++++++++++
 tb/tb_sblk_psum_acc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sblk_psum_acc.sv
// Partial-sum accumulation buffer closing a superblock stile cascade: read-modify-write
// accumulation over several passes, then a valid/ready drain. Optional macro: PSUM_ACC_SAT_EN.
module sblk_psum_acc #(
    parameter int WID_DSP              = 48,
    parameter int WID_PSUM             = 36,
    parameter int PSUM_SPLIT_START_POS = 12,
    parameter int WID_PSUMADDR         = 9,
    parameter int WID_PASS             = 8
) (
    input  logic                    clk_h,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [WID_PSUMADDR-1:0] cfg_len_m1,
    input  logic [WID_PASS-1:0]     cfg_npass_m1,
    input  logic                    in_valid,
    input  logic [WID_DSP-1:0]      in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WID_PSUM-1:0]     out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err_ovr
`ifdef PSUM_ACC_SAT_EN
    ,
    output logic                    sat_flag
`endif
);

    localparam int DEPTH = 1 << WID_PSUMADDR;
    localparam logic [WID_PSUMADDR-1:0] ADDR_ONE = 1;
    localparam logic [WID_PASS-1:0]     PASS_ONE = 1;
    localparam logic signed [WID_PSUM-1:0] PSUM_MAX = {1'b0, {(WID_PSUM-1){1'b1}}};
    localparam logic signed [WID_PSUM-1:0] PSUM_MIN = {1'b1, {(WID_PSUM-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_DRAIN} state_t;

    function automatic logic signed [WID_PSUM-1:0] psum_wrap_add(
        input logic signed [WID_PSUM-1:0] a,
        input logic signed [WID_PSUM-1:0] b);
        return a + b;
    endfunction

`ifdef PSUM_ACC_SAT_EN
    function automatic logic psum_ovf(
        input logic signed [WID_PSUM-1:0] a,
        input logic signed [WID_PSUM-1:0] b);
        logic signed [WID_PSUM:0] w;
        w = {a[WID_PSUM-1], a} + {b[WID_PSUM-1], b};
        return w[WID_PSUM] != w[WID_PSUM-1];
    endfunction

    function automatic logic signed [WID_PSUM-1:0] psum_sat_add(
        input logic signed [WID_PSUM-1:0] a,
        input logic signed [WID_PSUM-1:0] b);
        logic signed [WID_PSUM:0] w;
        w = {a[WID_PSUM-1], a} + {b[WID_PSUM-1], b};
        if (w[WID_PSUM] != w[WID_PSUM-1])
            return w[WID_PSUM] ? PSUM_MIN : PSUM_MAX;
        return w[WID_PSUM-1:0];
    endfunction
`endif

    state_t state_q, state_d;

    logic [WID_PSUMADDR-1:0] len_m1_q, acc_addr_q, drn_iss_addr_q, drn_pop_addr_q;
    logic [WID_PASS-1:0]     npass_m1_q, pass_q;
    logic                    flush_cnt_q, drn_iss_done_q, done_q, err_q;

    logic                    vld_p0, first_p0, fwd_p0;
    logic [WID_PSUMADDR-1:0] addr_p0;
    logic signed [WID_PSUM-1:0] x_p0, fwd_data_p0;

    logic                    wr_vld_p1;
    logic [WID_PSUMADDR-1:0] wr_addr_p1;
    logic signed [WID_PSUM-1:0] wr_data_p1;
    logic signed [WID_PSUM-1:0] rd_sel_p1, base_p1, sum_p1;
    logic                    sat_hit_p1;

    logic [WID_PSUM-1:0]     ram [DEPTH];
    logic [WID_PSUM-1:0]     ram_rd_q;
    logic                    rd_en, rd_vld_q;
    logic [WID_PSUMADDR-1:0] rd_addr;

    logic                    out_valid_q, sp_vld_q;
    logic [WID_PSUM-1:0]     out_data_q, sp_data_q;
    logic [1:0]              occ;

    logic start_ok, acc_take, acc_wrap, acc_last, pop, push, drn_issue, drain_end;
    logic fwd_now, fwd_old;
    logic signed [WID_PSUM-1:0] x_s0;
    logic unused_in_data;

    assign x_s0           = in_data[PSUM_SPLIT_START_POS +: WID_PSUM];
    assign unused_in_data = ^in_data;

    assign start_ok  = (state_q == S_IDLE) && cfg_start;
    assign acc_take  = (state_q == S_ACC) && in_valid;
    assign acc_wrap  = (acc_addr_q == len_m1_q);
    assign acc_last  = acc_take && acc_wrap && (pass_q == npass_m1_q);

    assign pop       = out_valid_q && out_ready;
    assign push      = rd_vld_q;
    assign occ       = {1'b0, out_valid_q} + {1'b0, sp_vld_q} + {1'b0, rd_vld_q};
    assign drn_issue = (state_q == S_DRAIN) && !drn_iss_done_q &&
                       ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign drain_end = pop && (drn_pop_addr_q == len_m1_q);

    assign rd_en   = acc_take || drn_issue;
    assign rd_addr = (state_q == S_DRAIN) ? drn_iss_addr_q : acc_addr_q;

    // S0 -> S1: S1 may be writing the very address S0 reads; forward that sum
    assign fwd_now = vld_p0 && (addr_p0 == acc_addr_q);
    assign fwd_old = wr_vld_p1 && (wr_addr_p1 == acc_addr_q);

    assign rd_sel_p1 = fwd_p0 ? fwd_data_p0 : ram_rd_q;
    assign base_p1   = first_p0 ? '0 : rd_sel_p1;
`ifdef PSUM_ACC_SAT_EN
    assign sum_p1     = psum_sat_add(base_p1, x_p0);
    assign sat_hit_p1 = psum_ovf(base_p1, x_p0);
`else
    assign sum_p1     = psum_wrap_add(base_p1, x_p0);
    assign sat_hit_p1 = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cfg_start)   state_d = S_ACC;
            S_ACC:   if (acc_last)    state_d = S_FLUSH;
            S_FLUSH: if (flush_cnt_q) state_d = S_DRAIN;
            S_DRAIN: if (drain_end)   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            len_m1_q       <= '0;
            npass_m1_q     <= '0;
            acc_addr_q     <= '0;
            pass_q         <= '0;
            flush_cnt_q    <= 1'b0;
            drn_iss_addr_q <= '0;
            drn_pop_addr_q <= '0;
            drn_iss_done_q <= 1'b0;
            vld_p0         <= 1'b0;
            wr_vld_p1      <= 1'b0;
            rd_vld_q       <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            if (start_ok) begin
                len_m1_q       <= cfg_len_m1;
                npass_m1_q     <= cfg_npass_m1;
                acc_addr_q     <= '0;
                pass_q         <= '0;
                flush_cnt_q    <= 1'b0;
                drn_iss_addr_q <= '0;
                drn_pop_addr_q <= '0;
                drn_iss_done_q <= 1'b0;
            end
            if (acc_take) begin
                if (acc_wrap) begin
                    acc_addr_q <= '0;
                    pass_q     <= pass_q + PASS_ONE;
                end else begin
                    acc_addr_q <= acc_addr_q + ADDR_ONE;
                end
            end
            if (state_q == S_FLUSH) flush_cnt_q <= ~flush_cnt_q;
            if (drn_issue) begin
                drn_iss_addr_q <= drn_iss_addr_q + ADDR_ONE;
                if (drn_iss_addr_q == len_m1_q) drn_iss_done_q <= 1'b1;
            end
            if (pop) drn_pop_addr_q <= drn_pop_addr_q + ADDR_ONE;
            vld_p0    <= acc_take;
            wr_vld_p1 <= vld_p0;
            rd_vld_q  <= drn_issue;
            done_q    <= drain_end;
            err_q     <= err_q | (in_valid && (state_q != S_ACC));
        end
    end

    always_ff @(posedge clk_h) begin
        if (acc_take) begin
            addr_p0     <= acc_addr_q;
            x_p0        <= x_s0;
            first_p0    <= (pass_q == '0);
            fwd_p0      <= fwd_now || fwd_old;
            fwd_data_p0 <= fwd_now ? sum_p1 : wr_data_p1;
        end
        if (vld_p0) begin
            wr_addr_p1 <= addr_p0;
            wr_data_p1 <= sum_p1;
        end
        if (push && (pop ? sp_vld_q : out_valid_q)) sp_data_q <= ram_rd_q;
    end

    always_ff @(posedge clk_h) begin
        if (vld_p0) ram[addr_p0] <= sum_p1;
        if (rd_en)  ram_rd_q     <= ram[rd_addr];
    end

    // Two-entry output skid: head drives the port, spare absorbs the in-flight read
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sp_vld_q    <= 1'b0;
            out_data_q  <= '0;
        end else if (pop) begin
            if (sp_vld_q) begin
                out_data_q <= sp_data_q;
                sp_vld_q   <= push;
            end else begin
                out_valid_q <= push;
                if (push) out_data_q <= ram_rd_q;
            end
        end else if (push) begin
            if (!out_valid_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ram_rd_q;
            end else begin
                sp_vld_q <= 1'b1;
            end
        end
    end

`ifdef PSUM_ACC_SAT_EN
    logic sat_q;
    always_ff @(posedge clk_h) begin
        if (!rst_n)                     sat_q <= 1'b0;
        else if (start_ok)              sat_q <= 1'b0;
        else if (vld_p0 && sat_hit_p1)  sat_q <= 1'b1;
    end
    assign sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_hit_p1 ^ PSUM_MAX[0] ^ PSUM_MIN[0];
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err_ovr   = err_q;

endmodule

// File: tb/tb_sblk_psum_acc.sv
// Directed bench for sblk_psum_acc: hand-computed accumulation jobs, drain backpressure,
// hazard forwarding, overflow behaviour and mid-job reset.
module tb_sblk_psum_acc;

    logic        clk_h = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [8:0]  cfg_len_m1;
    logic [7:0]  cfg_npass_m1;
    logic        in_valid;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_data;
    logic        busy;
    logic        done;
    logic        err_ovr;
`ifdef PSUM_ACC_SAT_EN
    logic        sat_flag;
`endif

    int checks   = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    always #5 clk_h = ~clk_h;

    sblk_psum_acc dut (
        .clk_h        (clk_h),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_len_m1   (cfg_len_m1),
        .cfg_npass_m1 (cfg_npass_m1),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .err_ovr      (err_ovr)
`ifdef PSUM_ACC_SAT_EN
        ,
        .sat_flag     (sat_flag)
`endif
    );

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [8:0] len, input logic [7:0] np);
        cfg_len_m1   = len;
        cfg_npass_m1 = np;
        cfg_start    = 1'b1;
        tick();
        cfg_start    = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    // Junk in the low 12 bits must be sliced away
    task automatic send(input logic [35:0] x, input bit gap);
        in_valid = 1'b1;
        in_data  = {x, 12'hABC};
        tick();
        in_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic drain_check(input string name, input int n, input bit toggle);
        int k = 0;
        int cyc = 0;
        bit pend = 0;
        bit phase = 1;
        logic [35:0] pend_data = '0;
        while (k < n && cyc < 300) begin
            out_ready = toggle ? phase : 1'b1;
            phase = ~phase;
            if (pend) begin
                check({name, "_stall_valid"}, out_valid, 1'b1);
                check({name, "_stall_data"}, out_data, pend_data);
            end
            if (out_valid && out_ready) begin
                check($sformatf("%s_data%0d", name, k), out_data, exp_q[k]);
                k++;
                pend = 0;
            end else if (out_valid) begin
                pend = 1;
                pend_data = out_data;
            end else begin
                pend = 0;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check({name, "_count"}, k, n);
        check({name, "_done"}, done, 1'b1);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_no_extra"}, out_valid, 1'b0);
        tick();
        check({name, "_done_low"}, done, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        cfg_start    = 1'b0;
        cfg_len_m1   = '0;
        cfg_npass_m1 = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err_ovr, 1'b0);
        check("rst_out_data", out_data, 36'd0);
        rst_n = 1'b1;
        tick();

        // 4 outputs x 3 passes, x = addr+1
        start_job(9'd3, 8'd2);
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < 4; a++) send(36'(a + 1), 1'b0);
        exp_q = '{36'd3, 36'd6, 36'd9, 36'd12};
        drain_check("j1", 4, 1'b0);

        // Single address, back-to-back: same-cycle forwarding
        start_job(9'd0, 8'd7);
        for (int i = 0; i < 8; i++) send(36'd5, 1'b0);
        exp_q = '{36'd40};
        drain_check("j2", 1, 1'b0);

        // Single address with one-cycle gaps: write-then-read spacing
        start_job(9'd0, 8'd2);
        for (int i = 0; i < 3; i++) send(36'd3, 1'b1);
        exp_q = '{36'd9};
        drain_check("j3", 1, 1'b0);

        // Negative sample
        start_job(9'd1, 8'd0);
        send(36'hF_FFFF_FFFF, 1'b0);
        send(36'hF_FFFF_FFFF, 1'b0);
        exp_q = '{36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF};
        drain_check("j4", 2, 1'b0);

        // Stale RAM (-1) must not leak into pass 0
        start_job(9'd1, 8'd0);
        send(36'd7, 1'b0);
        send(36'd9, 1'b0);
        exp_q = '{36'd7, 36'd9};
        drain_check("j5", 2, 1'b0);

        // Two passes with gaps, start ignored while busy, drain under toggling ready
        start_job(9'd7, 8'd1);
        cfg_len_m1 = 9'd0;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 8; a++) send(36'(a + 10), a[0]);
        exp_q.delete();
        for (int a = 0; a < 8; a++) exp_q.push_back(36'(2 * (a + 10)));
        drain_check("j6", 8, 1'b1);
        check("err_clean", err_ovr, 1'b0);

        // Overflow: two copies of max positive
        start_job(9'd0, 8'd1);
        send(36'h7_FFFF_FFFF, 1'b0);
        send(36'h7_FFFF_FFFF, 1'b0);
`ifdef PSUM_ACC_SAT_EN
        exp_q = '{36'h7_FFFF_FFFF};
        drain_check("j7", 1, 1'b0);
        check("sat_flag", sat_flag, 1'b1);
`else
        exp_q = '{36'hF_FFFF_FFFE};
        drain_check("j7", 1, 1'b0);
`endif

        // Reset mid-ACC, then a stray valid in IDLE
        start_job(9'd3, 8'd1);
        send(36'd1, 1'b0);
        send(36'd2, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        send(36'd100, 1'b0);
        check("err_sticky", err_ovr, 1'b1);
        check("err_busy", busy, 1'b0);
        check("err_done", done, 1'b0);
        start_job(9'd1, 8'd0);
        send(36'd4, 1'b0);
        send(36'd6, 1'b0);
        exp_q = '{36'd4, 36'd6};
        drain_check("j8", 2, 1'b0);
        check("err_still", err_ovr, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
